freq_gen: RTL and testbench
===========================

# freq_gen

Programmable square-wave generator: the stimulus-side counterpart of the frequency counter. A phase accumulator (DDS) clocked by sys_clk drives sig_out at a frequency set by a tuning word. The block runs either continuously or in bursts of an exact number of rising edges, so a known pulse count can be fed into the frequency counter's sig_in. Retuning is glitch-free: new words are applied only at a period boundary.

## Interface
- ACC_W, 32, phase accumulator width; output frequency = tune * f_sys_clk / 2^ACC_W
- CNT_W, 32, width of burst length and edge counter
- sys_clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- cfg_valid  in  1  configuration offer
- cfg_ready  out  1  configuration accepted when cfg_valid && cfg_ready at a rising edge
- cfg_tune  in  ACC_W  tuning word
- cfg_burst_len  in  CNT_W  rising edges to emit; 0 = continuous
- stop  in  1  level; requests an orderly stop
- sig_out  out  1  registered square wave
- busy  out  1  high in RUN and DRAIN
- edge_cnt  out  CNT_W  rising edges of sig_out since last start, saturating at all-ones
- done  out  1  one-cycle pulse on return to IDLE

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE: acc=0, sig_out=0, cfg_ready=1. On accept, latch tune, clamped to 2^(ACC_W-1) if larger, and latch burst_len. If the clamped tune is 0, stay in IDLE and pulse done. Otherwise clear acc and edge_cnt and go to RUN. stop is ignored in IDLE.
- RUN: each cycle acc <= acc + tune (mod 2^ACC_W); sig_out <= MSB of the new acc. A 0->1 transition of sig_out increments edge_cnt.
- Period boundary = carry out of the accumulator add. On a boundary sig_out is 0.
- Retune in RUN: cfg_ready=1 while no update is pending. An accepted word (clamped) is held in a shadow register and becomes the active tune for the add that follows the next boundary. cfg_burst_len is ignored in RUN. cfg_ready=0 while the update is pending.
- Burst: when the edge counter's next value equals burst_len (burst_len != 0), go to DRAIN in the same cycle.
- stop asserted in RUN: go to DRAIN. A burst end and stop in the same cycle both go to DRAIN.
- DRAIN: keep accumulating; cfg_ready=0; any pending retune is discarded. On the next boundary go to IDLE and pulse done; sig_out is 0 that cycle. edge_cnt does not change in DRAIN.
- edge_cnt holds its value in IDLE until the next start.

## Timing
- Reset values: sig_out 0, busy 0, edge_cnt 0, done 0, cfg_ready 1, state IDLE, acc 0, shadow empty.
- Accept at edge E: state=RUN after E; the first accumulate happens at edge E+1.
- sig_out, busy, edge_cnt and done are registered. cfg_ready is combinational from state and pending flag.
- Period = 2^ACC_W / tune cycles when it divides exactly; otherwise the average frequency is exact and individual periods vary by ±1 cycle.
- Duty cycle is 50% ±1 cycle.
- Async reset in any state forces reset values immediately, and sig_out can truncate mid-high. That truncation is the only way sig_out is cut short.

## Structure
- freq_gen_pkg:
  - state enum (IDLE/RUN/DRAIN)
  - default ACC_W/CNT_W
  - HALF_TUNE = 2^(ACC_W-1) clamp constant
- Sub-module phase_acc: accumulator plus shadow tune register; provides carry/boundary output, MSB output, and load/pending/discard controls.
- The top level holds the FSM, edge detection, edge counter and handshake.

## Test plan
- Tune 2^30, burst 0: sig_out pattern 0,1,1,0 repeating with period 4; first rise 2 cycles after accept edge; busy=1; edge_cnt increments every 4 cycles.
- Tune 2^30, burst 3: exactly 3 rises; done pulses 12 cycles after the accept edge with sig_out=0; then IDLE with edge_cnt=3 and cfg_ready=1.
- Tune 2^31 continuous, retune to 2^30 mid-period: toggling at period 2 continues until the next boundary, then switches to period 4 with no runt pulse; cfg_ready=0 while the update is pending.
- stop asserted in the high half of a period with tune 2^29: the current period completes (high 4 cycles), sig_out falls at the boundary, done pulses, and edge_cnt is unchanged.
- Tune 0xFFFF_FFFF: clamped to 2^31, output period 2. Tune 0: stays in IDLE, done pulses, sig_out stays 0.
- rst_n low during RUN: all outputs return to reset values immediately; after release a new accept with burst 1 yields exactly one rise.

Source files
------------

// File: rtl/freq_gen_pkg.sv
// Shared types and constants for the DDS square-wave generator.
// The tuning clamp keeps the output at or below half the sys_clk rate.
package freq_gen_pkg;

   localparam int DEF_ACC_W = 32;
   localparam int DEF_CNT_W = 32;

   localparam logic [DEF_ACC_W-1:0] HALF_TUNE = {1'b1, {(DEF_ACC_W-1){1'b0}}};

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_e;

endpackage

// File: rtl/freq_gen_phase_acc.sv
// Phase accumulator with a shadow tuning word that is swapped in only after
// a carry, so a retune never shortens the period in progress.
module freq_gen_phase_acc
   import freq_gen_pkg::*;
#(
   parameter int ACC_W = DEF_ACC_W
) (
   input  logic             sys_clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             start,
   input  logic             step,
   input  logic             shadow_load,
   input  logic             shadow_discard,
   input  logic [ACC_W-1:0] tune_in,
   output logic             carry,
   output logic             msb_next,
   output logic             pending
);

   logic [ACC_W-1:0] acc_r;
   logic [ACC_W-1:0] tune_r;
   logic [ACC_W-1:0] shadow_r;
   logic             pending_r;
   logic [ACC_W:0]   sum_s;
   logic             apply_s;

   // Next phase and the period-boundary condition.
   always_comb begin
      sum_s   = {1'b0, acc_r} + {1'b0, tune_r};
      apply_s = step & sum_s[ACC_W] & pending_r;
   end

   assign carry    = sum_s[ACC_W];
   assign msb_next = sum_s[ACC_W-1];
   assign pending  = pending_r;

   // Phase register.
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_r <= {ACC_W{1'b0}};
      end else if (clear || start) begin
         acc_r <= {ACC_W{1'b0}};
      end else if (step) begin
         acc_r <= sum_s[ACC_W-1:0];
      end else begin
         acc_r <= acc_r;
      end
   end

   // Active tune: loaded at start, replaced by the shadow after a boundary.
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         tune_r <= {ACC_W{1'b0}};
      end else if (start) begin
         tune_r <= tune_in;
      end else if (apply_s) begin
         tune_r <= shadow_r;
      end else begin
         tune_r <= tune_r;
      end
   end

   // Shadow word and its pending flag.
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow_r  <= {ACC_W{1'b0}};
         pending_r <= 1'b0;
      end else if (start || shadow_discard) begin
         shadow_r  <= shadow_r;
         pending_r <= 1'b0;
      end else if (shadow_load) begin
         shadow_r  <= tune_in;
         pending_r <= 1'b1;
      end else if (apply_s) begin
         shadow_r  <= shadow_r;
         pending_r <= 1'b0;
      end else begin
         shadow_r  <= shadow_r;
         pending_r <= pending_r;
      end
   end

endmodule

// File: rtl/freq_gen.sv
// Programmable square-wave generator: continuous or exact-count bursts,
// with retunes and stops that always finish the current period cleanly.
module freq_gen
   import freq_gen_pkg::*;
#(
   parameter int ACC_W = DEF_ACC_W,
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             sys_clk,
   input  logic             rst_n,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [ACC_W-1:0] cfg_tune,
   input  logic [CNT_W-1:0] cfg_burst_len,
   input  logic             stop,
   output logic             sig_out,
   output logic             busy,
   output logic [CNT_W-1:0] edge_cnt,
   output logic             done
);

   localparam logic [ACC_W-1:0] HALF_TUNE_L = {1'b1, {(ACC_W-1){1'b0}}};
   localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

   state_e           state_r;
   state_e           state_nx_s;
   logic             sig_out_r;
   logic             busy_r;
   logic             done_r;
   logic [CNT_W-1:0] edge_cnt_r;
   logic [CNT_W-1:0] burst_len_r;
   logic             sig_nx_s;
   logic             done_nx_s;
   logic [CNT_W-1:0] edge_nx_s;
   logic [CNT_W-1:0] edge_inc_s;
   logic [ACC_W-1:0] tune_clamp_s;
   logic             acc_clear_s;
   logic             acc_start_s;
   logic             acc_step_s;
   logic             sh_load_s;
   logic             sh_discard_s;
   logic             carry_s;
   logic             msb_s;
   logic             pending_s;
   logic             rise_s;
   logic             burst_end_s;
   logic             cfg_ready_s;

   assign tune_clamp_s = (cfg_tune > HALF_TUNE_L) ? HALF_TUNE_L : cfg_tune;
   assign rise_s       = msb_s & ~sig_out_r;
   assign edge_inc_s   = (rise_s && (edge_cnt_r != CNT_MAX)) ? edge_cnt_r + CNT_ONE : edge_cnt_r;
   assign burst_end_s  = (burst_len_r != {CNT_W{1'b0}}) && (edge_inc_s == burst_len_r);

   freq_gen_phase_acc #(.ACC_W(ACC_W)) u_phase_acc (
      .sys_clk        (sys_clk),
      .rst_n          (rst_n),
      .clear          (acc_clear_s),
      .start          (acc_start_s),
      .step           (acc_step_s),
      .shadow_load    (sh_load_s),
      .shadow_discard (sh_discard_s),
      .tune_in        (tune_clamp_s),
      .carry          (carry_s),
      .msb_next       (msb_s),
      .pending        (pending_s)
   );

   // Next-state and datapath control.
   always_comb begin
      state_nx_s   = state_r;
      sig_nx_s     = sig_out_r;
      done_nx_s    = 1'b0;
      edge_nx_s    = edge_cnt_r;
      acc_clear_s  = 1'b0;
      acc_start_s  = 1'b0;
      acc_step_s   = 1'b0;
      sh_load_s    = 1'b0;
      sh_discard_s = 1'b0;
      cfg_ready_s  = 1'b0;
      case (state_r)
         ST_IDLE: begin
            cfg_ready_s = 1'b1;
            acc_clear_s = 1'b1;
            sig_nx_s    = 1'b0;
            if (cfg_valid && (tune_clamp_s == {ACC_W{1'b0}})) begin
               done_nx_s = 1'b1;
            end else if (cfg_valid) begin
               acc_start_s = 1'b1;
               edge_nx_s   = {CNT_W{1'b0}};
               state_nx_s  = ST_RUN;
            end else begin
               state_nx_s = ST_IDLE;
            end
         end
         ST_RUN: begin
            cfg_ready_s = ~pending_s;
            acc_step_s  = 1'b1;
            sig_nx_s    = msb_s;
            edge_nx_s   = edge_inc_s;
            sh_load_s   = cfg_valid & ~pending_s;
            if (burst_end_s || stop) begin
               state_nx_s = ST_DRAIN;
            end else begin
               state_nx_s = ST_RUN;
            end
         end
         ST_DRAIN: begin
            acc_step_s   = 1'b1;
            sh_discard_s = 1'b1;
            sig_nx_s     = msb_s;
            // A carry always lands with the new MSB low, so the wave ends low.
            if (carry_s) begin
               acc_clear_s = 1'b1;
               sig_nx_s    = 1'b0;
               done_nx_s   = 1'b1;
               state_nx_s  = ST_IDLE;
            end else begin
               state_nx_s = ST_DRAIN;
            end
         end
         default: begin
            acc_clear_s = 1'b1;
            sig_nx_s    = 1'b0;
            state_nx_s  = ST_IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // Registered outputs and the latched burst length.
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         sig_out_r   <= 1'b0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         edge_cnt_r  <= {CNT_W{1'b0}};
         burst_len_r <= {CNT_W{1'b0}};
      end else begin
         sig_out_r   <= sig_nx_s;
         busy_r      <= (state_nx_s != ST_IDLE);
         done_r      <= done_nx_s;
         edge_cnt_r  <= edge_nx_s;
         burst_len_r <= acc_start_s ? cfg_burst_len : burst_len_r;
      end
   end

   assign cfg_ready = cfg_ready_s;
   assign sig_out   = sig_out_r;
   assign busy      = busy_r;
   assign done      = done_r;
   assign edge_cnt  = edge_cnt_r;

endmodule

// File: tb/tb_freq_gen.sv
// Scoreboard bench for freq_gen: a phase-arithmetic reference predicts every
// rising edge and done pulse, and a negedge monitor checks them as they occur.
module tb_freq_gen;

   localparam int ACC_W = 32;
   localparam int CNT_W = 32;

   logic             sys_clk = 1'b0;
   logic             rst_n = 1'b1;
   logic             cfg_valid = 1'b0;
   logic             cfg_ready;
   logic [ACC_W-1:0] cfg_tune = 32'd0;
   logic [CNT_W-1:0] cfg_burst_len = 32'd0;
   logic             stop = 1'b0;
   logic             sig_out;
   logic             busy;
   logic [CNT_W-1:0] edge_cnt;
   logic             done;

   freq_gen #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
      .sys_clk       (sys_clk),
      .rst_n         (rst_n),
      .cfg_valid     (cfg_valid),
      .cfg_ready     (cfg_ready),
      .cfg_tune      (cfg_tune),
      .cfg_burst_len (cfg_burst_len),
      .stop          (stop),
      .sig_out       (sig_out),
      .busy          (busy),
      .edge_cnt      (edge_cnt),
      .done          (done)
   );

   always #5 sys_clk = ~sys_clk;

   int cyc = 0;
   always @(posedge sys_clk) cyc <= cyc + 1;

   int   n_checks = 0;
   int   n_errors = 0;
   int   done_cnt = 0;
   int   last_cnt = 0;
   bit   mon_en = 1'b0;
   logic sig_prev = 1'b0;

   int exp_rise_cyc[$];
   int exp_rise_cnt[$];
   int exp_done_cyc[$];
   int exp_done_cnt[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic longint unsigned clamp_t(input logic [31:0] w);
      return (w > 32'h8000_0000) ? 64'h8000_0000 : {32'h0, w};
   endfunction

   // Reference: output bit 31 of the running phase, boundaries are wraps past 2^32.
   task automatic model_run(input logic [31:0] tune_raw, input int burst, input int stop_k,
                            input int rt_k, input logic [31:0] rt_word, input int e);
      longint unsigned ph, t, sh;
      bit carry, sig, prev, pend, pend0, drain;
      int cnt;
      t = clamp_t(tune_raw);
      if (t == 64'd0) begin
         exp_done_cyc.push_back(e);
         exp_done_cnt.push_back(last_cnt);
         return;
      end
      ph = 0; sh = 0; prev = 0; pend = 0; drain = 0; cnt = 0;
      for (int k = 1; k < 10000; k++) begin
         pend0 = pend;
         ph    = ph + t;
         carry = (ph >= 64'h1_0000_0000);
         ph    = ph % 64'h1_0000_0000;
         sig   = (ph >= 64'h8000_0000);
         if (!drain) begin
            if (carry && pend) begin
               t = sh;
               pend = 0;
            end
            if (sig && !prev) begin
               cnt++;
               exp_rise_cyc.push_back(e + k);
               exp_rise_cnt.push_back(cnt);
            end
            if (k == rt_k && !pend0) begin
               pend = 1;
               sh = clamp_t(rt_word);
            end
            if ((burst != 0 && cnt == burst) || k == stop_k) drain = 1;
         end else begin
            pend = 0;
            if (carry) begin
               exp_done_cyc.push_back(e + k);
               exp_done_cnt.push_back(cnt);
               last_cnt = cnt;
               return;
            end
            if (sig && !prev) begin
               exp_rise_cyc.push_back(e + k);
               exp_rise_cnt.push_back(cnt);
            end
         end
         prev = sig;
      end
   endtask

   // Monitor: every rising edge and done pulse is matched against the scoreboard.
   always @(negedge sys_clk) begin
      if (mon_en) begin
         if (sig_out === 1'b1 && sig_prev === 1'b0) begin
            if (exp_rise_cyc.size() == 0) begin
               check("unexpected_rise", 64'(cyc), 64'hFFFF_FFFF);
            end else begin
               check("rise_cycle", 64'(cyc), 64'(exp_rise_cyc.pop_front()));
               check("rise_edge_cnt", 64'(edge_cnt), 64'(exp_rise_cnt.pop_front()));
               check("rise_busy", 64'(busy), 64'd1);
            end
         end
         if (done === 1'b1) begin
            done_cnt++;
            if (exp_done_cyc.size() == 0) begin
               check("unexpected_done", 64'(cyc), 64'hFFFF_FFFF);
            end else begin
               check("done_cycle", 64'(cyc), 64'(exp_done_cyc.pop_front()));
               check("done_edge_cnt", 64'(edge_cnt), 64'(exp_done_cnt.pop_front()));
               check("done_sig_low", 64'(sig_out), 64'd0);
               check("done_busy_low", 64'(busy), 64'd0);
               check("done_cfg_ready", 64'(cfg_ready), 64'd1);
            end
         end
      end
      sig_prev = sig_out;
   end

   // Starts one run from IDLE and drives stop / retune at the requested phase steps.
   task automatic do_run(input logic [31:0] tune, input int burst, input int stop_k,
                         input int rt_k, input logic [31:0] rt_word);
      int e;
      int d0;
      e  = cyc + 1;
      d0 = done_cnt;
      model_run(tune, burst, stop_k, rt_k, rt_word, e);
      cfg_valid = 1'b1;
      cfg_tune = tune;
      cfg_burst_len = burst;
      @(posedge sys_clk); #1;
      cfg_valid = 1'b0;
      for (int i = 0; i < 5000 && done_cnt == d0; i++) begin
         stop = (cyc + 1 == e + stop_k);
         if (cyc + 1 == e + rt_k) begin
            cfg_valid = 1'b1;
            cfg_tune = rt_word;
            cfg_burst_len = $urandom;
         end else begin
            cfg_valid = 1'b0;
         end
         @(posedge sys_clk); #1;
         if (rt_k > 0 && cyc == e + rt_k) check("ready_low_pending", 64'(cfg_ready), 64'd0);
      end
      stop = 1'b0;
      cfg_valid = 1'b0;
      if (done_cnt == d0) check("done_timeout", 64'd0, 64'd1);
      @(posedge sys_clk); #1;
   endtask

   logic [31:0] tw, rw;
   int b, sk, rk, e0;

   initial begin
      #2 rst_n = 1'b0;
      repeat (2) @(posedge sys_clk);
      #1;
      check("rst_sig_out", 64'(sig_out), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_edge_cnt", 64'(edge_cnt), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_cfg_ready", 64'(cfg_ready), 64'd1);
      @(negedge sys_clk) rst_n = 1'b1;
      @(posedge sys_clk); #1;
      mon_en = 1'b1;

      do_run(32'h4000_0000, 0, 13, 0, 32'd0);
      do_run(32'h4000_0000, 3, 0, 0, 32'd0);
      do_run(32'h8000_0000, 0, 20, 5, 32'h4000_0000);
      do_run(32'h2000_0000, 0, 5, 0, 32'd0);
      do_run(32'hFFFF_FFFF, 2, 0, 0, 32'd0);
      do_run(32'h0000_0000, 3, 0, 0, 32'd0);

      // Asynchronous reset while the output is high.
      mon_en = 1'b0;
      e0 = cyc + 1;
      cfg_valid = 1'b1;
      cfg_tune = 32'h4000_0000;
      cfg_burst_len = 32'd0;
      @(posedge sys_clk); #1;
      cfg_valid = 1'b0;
      repeat (6) @(posedge sys_clk);
      #1;
      check("pre_reset_high", 64'(sig_out), 64'd1);
      check("pre_reset_busy", 64'(busy), 64'd1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_sig_out", 64'(sig_out), 64'd0);
      check("mid_rst_busy", 64'(busy), 64'd0);
      check("mid_rst_edge_cnt", 64'(edge_cnt), 64'd0);
      check("mid_rst_done", 64'(done), 64'd0);
      check("mid_rst_cfg_ready", 64'(cfg_ready), 64'd1);
      #1 rst_n = 1'b1;
      @(posedge sys_clk); #1;
      last_cnt = 0;
      mon_en = 1'b1;
      do_run(32'h4000_0000, 1, 0, 0, 32'd0);

      for (int n = 0; n < 12; n++) begin
         case ($urandom_range(0, 3))
            0: tw = 32'h1000_0000 << $urandom_range(0, 3);
            1: tw = $urandom_range(32'hFFFF_FFFF, 32'h0400_0000);
            2: tw = $urandom_range(32'h8000_0000, 32'h0400_0000);
            default: tw = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'h8000_0000;
         endcase
         b = $urandom_range(0, 4);
         sk = 0;
         rk = 0;
         rw = 32'd0;
         if (b == 0) begin
            sk = $urandom_range(1, 120);
            if ($urandom_range(0, 1) == 1) begin
               rk = $urandom_range(1, sk);
               rw = $urandom_range(32'hFFFF_FFFF, 32'h0400_0000);
            end
         end
         do_run(tw, b, sk, rk, rw);
      end

      check("rise_queue_empty", 64'(exp_rise_cyc.size()), 64'd0);
      check("done_queue_empty", 64'(exp_done_cyc.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
